// File: rtl/neuron_integrate_fire.sv
// Leaky integrate-and-fire array: accumulates multiplier products per neuron and sweeps all neurons on each tick.
// Optional build macro SPIKE_REFRACTORY_EN adds a one-evaluation refractory period after each spike.
module neuron_integrate_fire #(
    parameter int NUM_NEURONS = 16,
    parameter int ID_WIDTH    = $clog2(NUM_NEURONS),
    parameter int POT_WIDTH   = 32,
    parameter int LEAK_SHIFT  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    input  logic [ID_WIDTH-1:0]         issue_nid,
    input  logic                        mul_done,
    input  logic [31:0]                 mul_answer,
    input  logic                        tick,
    input  logic signed [POT_WIDTH-1:0] threshold,
    input  logic signed [POT_WIDTH-1:0] reset_potential,
    output logic                        spike_valid,
    output logic [ID_WIDTH-1:0]         spike_nid,
    output logic                        busy,
    output logic [1:0]                  err
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SWEEP} state_t;

    localparam logic signed [POT_WIDTH-1:0] POT_MAX = {1'b0, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [POT_WIDTH-1:0] POT_MIN = {1'b1, {(POT_WIDTH-1){1'b0}}};
    localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_NEURONS - 1);

    state_t                      state_q, state_d;
    logic [ID_WIDTH-1:0]         idx_q, idx_d;
    logic [ID_WIDTH-1:0]         tag_q, tag_d;
    logic                        pending_q, pending_d;
    logic [1:0]                  err_q, err_d;
    logic                        spike_valid_q, spike_valid_d;
    logic [ID_WIDTH-1:0]         spike_nid_q, spike_nid_d;
    logic signed [POT_WIDTH-1:0] pot_q [NUM_NEURONS];
    logic signed [POT_WIDTH-1:0] pot_d [NUM_NEURONS];
`ifdef SPIKE_REFRACTORY_EN
    logic [NUM_NEURONS-1:0]      refr_q, refr_d;
`endif

    logic signed [POT_WIDTH-1:0] product;
    logic signed [POT_WIDTH-1:0] p;
    logic signed [POT_WIDTH-1:0] v;
    logic                        retire;

    assign product = mul_answer;

    function automatic logic signed [POT_WIDTH-1:0] sat_add(
        input logic signed [POT_WIDTH-1:0] a,
        input logic signed [POT_WIDTH-1:0] b
    );
        logic signed [POT_WIDTH:0] s;
        s = {a[POT_WIDTH-1], a} + {b[POT_WIDTH-1], b};
        if (s[POT_WIDTH] != s[POT_WIDTH-1]) begin
            return s[POT_WIDTH] ? POT_MIN : POT_MAX;
        end
        return s[POT_WIDTH-1:0];
    endfunction

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        tag_d         = tag_q;
        pending_d     = pending_q;
        err_d         = err_q;
        spike_valid_d = 1'b0;
        spike_nid_d   = spike_nid_q;
        pot_d         = pot_q;
`ifdef SPIKE_REFRACTORY_EN
        refr_d        = refr_q;
`endif
        p      = '0;
        v      = '0;
        retire = mul_done && pending_q;

        if ((mul_done && !pending_q) || (issue_valid && pending_q && !mul_done)) begin
            err_d[0] = 1'b1;
        end
        if (tick && state_q != ST_IDLE) begin
            err_d[1] = 1'b1;
        end

        // Retire first so a same-cycle issue can reuse the single tag slot.
        if (retire) begin
            pending_d = 1'b0;
`ifdef SPIKE_REFRACTORY_EN
            if (!refr_q[tag_q])
`endif
            pot_d[tag_q] = sat_add(pot_q[tag_q], product);
        end
        if (issue_valid && (!pending_q || mul_done)) begin
            tag_d     = issue_nid;
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = pending_q ? ST_WAIT : ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_WAIT: begin
                if (!pending_d) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                // Reading pot_d folds in a product retiring to this same neuron.
                p = pot_d[idx_q];
                v = p - (p >>> LEAK_SHIFT);
`ifdef SPIKE_REFRACTORY_EN
                if (refr_q[idx_q]) begin
                    pot_d[idx_q]  = v;
                    refr_d[idx_q] = 1'b0;
                end else
`endif
                if (v >= threshold) begin
                    pot_d[idx_q]  = reset_potential;
                    spike_valid_d = 1'b1;
                    spike_nid_d   = idx_q;
`ifdef SPIKE_REFRACTORY_EN
                    refr_d[idx_q] = 1'b1;
`endif
                end else begin
                    pot_d[idx_q] = v;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            tag_q         <= '0;
            pending_q     <= 1'b0;
            err_q         <= '0;
            spike_valid_q <= 1'b0;
            spike_nid_q   <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_q[i] <= '0;
            end
`ifdef SPIKE_REFRACTORY_EN
            refr_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tag_q         <= tag_d;
            pending_q     <= pending_d;
            err_q         <= err_d;
            spike_valid_q <= spike_valid_d;
            spike_nid_q   <= spike_nid_d;
            pot_q         <= pot_d;
`ifdef SPIKE_REFRACTORY_EN
            refr_q        <= refr_d;
`endif
        end
    end

    assign spike_valid = spike_valid_q;
    assign spike_nid   = spike_nid_q;
    assign busy        = (state_q != ST_IDLE);
    assign err         = err_q;

endmodule

// File: tb/tb_neuron_integrate_fire.sv
// Randomized and directed bench for neuron_integrate_fire against a transaction-level potential model.
module tb_neuron_integrate_fire;
    localparam int N  = 16;
    localparam int IW = 4;
`ifdef SPIKE_REFRACTORY_EN
    localparam bit REFR_EN = 1'b1;
`else
    localparam bit REFR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic issue_valid;
    logic [IW-1:0] issue_nid;
    logic mul_done;
    logic [31:0] mul_answer;
    logic tick;
    logic signed [31:0] threshold;
    logic signed [31:0] reset_potential;
    logic spike_valid;
    logic [IW-1:0] spike_nid;
    logic busy;
    logic [1:0] err;

    neuron_integrate_fire #(.NUM_NEURONS(N)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_nid(issue_nid),
        .mul_done(mul_done), .mul_answer(mul_answer), .tick(tick),
        .threshold(threshold), .reset_potential(reset_potential),
        .spike_valid(spike_valid), .spike_nid(spike_nid), .busy(busy), .err(err)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    // reference model
    longint m_pot [N];
    bit     m_refr [N];
    bit     m_pending;
    int     m_tag;
    logic [1:0] m_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic longint sat(input longint a, input longint b);
        longint s;
        s = a + b;
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s;
    endfunction

    function automatic longint leak(input longint p);
        longint sh;
        sh = (p >= 0) ? p / 16 : -((-p + 15) / 16);
        return p - sh;
    endfunction

    function automatic void model_retire(input longint ans);
        if (!m_pending) begin
            m_err[0] = 1'b1;
            return;
        end
        if (!(REFR_EN && m_refr[m_tag])) m_pot[m_tag] = sat(m_pot[m_tag], ans);
        m_pending = 1'b0;
    endfunction

    function automatic logic [31:0] model_eval(input int i);
        longint v;
        v = leak(m_pot[i]);
        if (REFR_EN && m_refr[i]) begin
            m_pot[i]  = v;
            m_refr[i] = 1'b0;
            return 32'd0;
        end
        if (v >= longint'(threshold)) begin
            m_pot[i]  = longint'(reset_potential);
            m_refr[i] = 1'b1;
            return 32'h10 | 32'(i);
        end
        m_pot[i] = v;
        return 32'd0;
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input int nid);
        issue_valid = 1'b1;
        issue_nid   = IW'(nid);
        step();
        issue_valid = 1'b0;
        m_pending   = 1'b1;
        m_tag       = nid;
    endtask

    task automatic do_done(input int ans);
        mul_done   = 1'b1;
        mul_answer = 32'(ans);
        step();
        mul_done   = 1'b0;
        model_retire(longint'(ans));
    endtask

    task automatic check_pots(input string tag);
        for (int i = 0; i < N; i++) check_eq($sformatf("%s_pot%0d", tag, i), dut.pot_q[i], 32'(m_pot[i]));
    endtask

    // Caller is in the first sweep cycle; optional issue/done/tick land in the cycle that evaluates that index.
    task automatic check_sweep(input string tag, input int iss_at, input int iss_nid,
                               input int done_at, input int ans, input int tick_at);
        for (int i = 0; i < N; i++) begin
            if (i == iss_at) begin m_pending = 1'b1; m_tag = iss_nid; end
            if (i == done_at) model_retire(longint'(ans));
            if (i == tick_at) m_err[1] = 1'b1;
            exp_q.push_back(model_eval(i));
        end
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
            issue_valid = (i == iss_at);
            issue_nid   = IW'(iss_nid);
            mul_done    = (i == done_at);
            mul_answer  = 32'(ans);
            tick        = (i == tick_at);
            step();
            issue_valid = 1'b0;
            mul_done    = 1'b0;
            tick        = 1'b0;
            check_eq($sformatf("%s_spike%0d", tag, i),
                     spike_valid ? (32'h10 | 32'(spike_nid)) : 32'd0, exp_q.pop_front());
        end
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        check_pots(tag);
    endtask

    task automatic tick_sweep(input string tag, input int tick_at);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check_sweep(tag, -1, 0, -1, 0, tick_at);
    endtask

    initial begin
        int ans;
        rst = 1'b1; issue_valid = 0; issue_nid = '0; mul_done = 0; mul_answer = '0;
        tick = 0; threshold = 1; reset_potential = 0;
        for (int i = 0; i < N; i++) begin m_pot[i] = 0; m_refr[i] = 0; end
        m_pending = 0; m_tag = 0; m_err = 2'b00;
        step(); step();
        check_eq("rst_spike_valid", 32'(spike_valid), 32'd0);
        check_eq("rst_spike_nid", 32'(spike_nid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        step();

        // empty sweep, all potentials stay zero
        tick_sweep("empty", -1);
        check_eq("empty_err", 32'(err), 32'(m_err));

        // single product crosses threshold after leak
        threshold = 90; reset_potential = 0;
        do_issue(3); do_done(100);
        tick_sweep("fire3", -1);
        tick_sweep("fire3_again", -1);

        // saturation, then negative product with threshold 0
        threshold = 32'sh7FFF_FFFF;
        do_issue(0); do_done(32'h7000_0000);
        do_issue(0); do_done(32'h7000_0000);
        check_pots("sat");
        threshold = 0;
        do_issue(7); do_done(32'hFFFF_FF00);
        tick_sweep("neg", -1);

        // repeated product to a neuron that just spiked
        threshold = 90; reset_potential = 5;
        do_issue(2); do_done(100);
        tick_sweep("refr_a", -1);
        do_issue(2); do_done(200);
        check_pots("refr_pre");
        tick_sweep("refr_b", -1);

        // products retiring during a sweep: same index, earlier index, later index
        threshold = 60; reset_potential = -3;
        tick = 1'b1; step(); tick = 1'b0;
        check_sweep("mid_same", 1, 6, 6, 500, -1);
        tick = 1'b1; step(); tick = 1'b0;
        check_sweep("mid_early", 2, 1, 4, 300, -1);
        tick = 1'b1; step(); tick = 1'b0;
        check_sweep("mid_late", 2, 12, 4, 300, -1);

        // randomized rounds
        for (int r = 0; r < 8; r++) begin
            threshold       = int'($urandom_range(0, 300)) - 50;
            reset_potential = int'($urandom_range(0, 40)) - 20;
            for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
                do_issue(int'($urandom_range(0, N - 1)));
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
                ans = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 400)) - 200;
                do_done(ans);
            end
            check_pots($sformatf("rnd%0d_pre", r));
            tick_sweep($sformatf("rnd%0d", r), -1);
        end
        check_eq("rnd_err", 32'(err), 32'(m_err));

        // tick while a product is outstanding waits for the retire
        threshold = 40; reset_potential = 0;
        for (int i = 0; i < N; i++) begin
            if (m_pot[i] != 0) begin
                // drain any leftover potential so neuron 5 sees only the new product
                threshold = 32'sh8000_0000;
            end
        end
        if (threshold != 40) begin
            tick_sweep("drain", -1);
            threshold = 32'sh8000_0000;
            tick_sweep("drain2", -1);
            reset_potential = 0;
        end
        threshold = 32'sh7FFF_FFFF;
        issue_valid = 1'b1; issue_nid = IW'(5);
        step();
        issue_valid = 1'b0; m_pending = 1'b1; m_tag = 5;
        tick = 1'b1;
        step();
        tick = 1'b0;
        check_eq("wait_busy1", 32'(busy), 32'd1);
        step();
        check_eq("wait_busy2", 32'(busy), 32'd1);
        check_eq("wait_nospike", 32'(spike_valid), 32'd0);
        step();
        check_eq("wait_busy3", 32'(busy), 32'd1);
        do_done(50);
        check_sweep("wait", -1, 0, -1, 0, -1);

        // orphan product, then a tick landing mid-sweep
        do_done(77);
        check_eq("orphan_err", 32'(err), 32'(m_err));
        check_pots("orphan");
        tick_sweep("overrun", 5);
        check_eq("overrun_err", 32'(err), 32'(m_err));
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("post_spike%0d", i), 32'(spike_valid), 32'd0);
            check_eq($sformatf("post_busy%0d", i), 32'(busy), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/neuron_integrate_fire.md
Name: neuron_integrate_fire

Overview:
Downstream consumer of the neuron multiplier. It captures each weighted product (synaptic weight × input) when the multiplier signals done, and accumulates it into a per-neuron membrane potential. On each timestep tick it sweeps all neurons, applying leak, a threshold compare, spike emission and potential reset. The spike output feeds the core's spike router.

Parameters:
- NUM_NEURONS, 16, number of neurons; potential register file depth.
- ID_WIDTH, $clog2(NUM_NEURONS), neuron index width.
- POT_WIDTH, 32, signed membrane potential width; must equal the product width.
- LEAK_SHIFT, 4, leak amount = pot >>> LEAK_SHIFT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  a multiply was accepted this cycle (start && multiplier_ready).
- issue_nid  in  ID_WIDTH  target neuron of the accepted multiply.
- mul_done  in  1  product valid this cycle.
- mul_answer  in  32  product; treated as signed.
- tick  in  1  timestep pulse.
- threshold  in  POT_WIDTH  signed firing threshold.
- reset_potential  in  POT_WIDTH  signed value loaded on spike.
- spike_valid  out  1  one-cycle spike pulse.
- spike_nid  out  ID_WIDTH  index of the spiking neuron.
- busy  out  1  a tick is being processed.
- err  out  2  sticky errors: [0] protocol, [1] tick overrun.

Behaviour:
- Reset (asynchronous): all potentials 0, pending=0, state IDLE, spike_valid=0, spike_nid=0, busy=0, err=0. Reset mid-sweep aborts the sweep and emits no further spikes.
- Tag tracking: the multiplier carries no tag, so the block holds one tag register plus a pending bit (the multiplier allows one outstanding operation).
  - issue_valid with pending=0: latch issue_nid, set pending.
  - issue_valid with pending=1 and no mul_done in the same cycle: ignore it and set err[0].
  - mul_done with pending=1: pot[tag] <= sat(pot[tag] + mul_answer), then clear pending.
  - mul_done with pending=0: drop the product and set err[0].
  - mul_done and issue_valid in the same cycle: retire the old tag first, then latch the new tag; pending stays 1.
- Saturating add: signed POT_WIDTH. Positive overflow clamps to 0x7FFF_FFFF; negative overflow clamps to 0x8000_0000.
- State machine IDLE / WAIT / SWEEP:
  - IDLE: on tick, go to WAIT if pending=1, else to SWEEP with idx=0.
  - WAIT: hold until pending clears (mul_done retired), then go to SWEEP with idx=0.
  - SWEEP: evaluate one neuron per cycle. v = p − (p >>> LEAK_SHIFT), using an arithmetic shift.
    - If v >= threshold (signed): pot[idx] <= reset_potential, and spike fires.
    - Otherwise: pot[idx] <= v.
    - After idx = NUM_NEURONS−1, return to IDLE.
- busy = 1 in WAIT and SWEEP.
- Timing: tick sampled at cycle T with pending=0 → neuron i is evaluated in T+1+i. spike_valid and spike_nid are registered and asserted in T+2+i. Sweep length is exactly NUM_NEURONS cycles.
- mul_done during SWEEP is accepted.
  - If its tag equals the idx being evaluated, p = sat(pot + product) before leak/threshold.
  - Otherwise it writes its own neuron normally.
- tick while busy=1: ignored; set err[1].
- threshold and reset_potential are sampled on each evaluation cycle and are not latched at tick.
- Errors clear only on rst.

Optional Feature:
SPIKE_REFRACTORY_EN
- Defined: adds a per-neuron refractory bit, reset to 0.
  - Set on spike.
  - Products retiring to a refractory neuron are discarded (pending still clears; no error).
  - The neuron's next sweep evaluation applies leak only, skips the threshold compare (no spike possible), and clears the bit.
- Undefined: no refractory state; products always accumulate and every evaluation compares against threshold.

Test Plan:
1. Release rst; threshold=1; tick at T → busy high T+1..T+16, no spike_valid; err=0; all potentials remain 0.
2. issue_valid nid=3, then mul_done answer=100; threshold=90, reset_potential=0; tick at T → leak gives 94 ≥ 90 → spike_valid=1, spike_nid=3 at T+5 only; next tick produces no spike for nid 3.
3. Two products 0x7000_0000 to nid 0 → pot[0]=0x7FFF_FFFF (saturated); a separate run with answer 0xFFFF_FF00 to nid 7 and threshold=0 → after tick pot[7] = −240, no spike.
4. issue_valid nid=5, tick 1 cycle later, mul_done answer=50 three cycles after tick → busy high from tick+1; SWEEP starts the cycle after done; nid 5 evaluated with 50 (leak → 47).
5. mul_done with no prior issue → err=2'b01, potentials unchanged; a tick asserted during SWEEP → err=2'b11 and no second sweep occurs.
6. With SPIKE_REFRACTORY_EN: nid 2 spikes, then a product of 200 targets nid 2 → discarded; next tick produces no spike for nid 2 and clears its refractory bit.
